// File: rtl/db_client_if.sv
// rtl/db_client_if.sv - Handshake bundle between packet parser, filter DB and forwarding path.
interface db_client_if #(
   parameter int KEY_SIZE  = 96,
   parameter int FLAG_SIZE = 4,
   parameter int TAG_W     = 8
);
   logic                 pkt_valid;
   logic                 pkt_ready;
   logic [31:0]          pkt_src_ip;
   logic [31:0]          pkt_dst_ip;
   logic [15:0]          pkt_dst_port;
   logic [FLAG_SIZE-1:0] pkt_op;
   logic [TAG_W-1:0]     pkt_tag;

   logic [KEY_SIZE-1:0]  db_in_key;
   logic [FLAG_SIZE-1:0] db_in_flag;
   logic                 db_in_valid;
   logic                 db_in_ready;
   logic                 db_out_valid;
   logic [FLAG_SIZE-1:0] db_out_flag;

   logic                 vd_valid;
   logic [TAG_W-1:0]     vd_tag;
   logic [FLAG_SIZE-1:0] vd_flag;
   logic                 vd_drop;
   logic                 vd_timeout;

   modport slave (
      input  pkt_valid, pkt_src_ip, pkt_dst_ip, pkt_dst_port, pkt_op, pkt_tag,
      output pkt_ready,
      output db_in_key, db_in_flag, db_in_valid,
      input  db_in_ready, db_out_valid, db_out_flag,
      output vd_valid, vd_tag, vd_flag, vd_drop, vd_timeout
   );

   modport master (
      output pkt_valid, pkt_src_ip, pkt_dst_ip, pkt_dst_port, pkt_op, pkt_tag,
      input  pkt_ready,
      input  db_in_key, db_in_flag, db_in_valid,
      output db_in_ready, db_out_valid, db_out_flag,
      input  vd_valid, vd_tag, vd_flag, vd_drop, vd_timeout
   );
endinterface

// File: rtl/db_client.sv
// rtl/db_client.sv - Filter DB requester: in-order tag tracking, pass/drop verdicts, timeout recovery.
// Optional statistics counters built only when DB_CLIENT_STATS_EN is defined.
module db_client #(
   parameter int KEY_SIZE  = 96,
   parameter int FLAG_SIZE = 4,
   parameter int TAG_W     = 8,
   parameter int DEPTH     = 8,
   parameter int TIMEOUT   = 1023
) (
   input  logic        clk,
   input  logic        rst,
   db_client_if.slave  bus,
   output logic        err_unexp_o,
   output logic [31:0] stat_req_o,
   output logic [31:0] stat_drop_o,
   output logic [31:0] stat_tmo_o
);
   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = AW + 1;
   localparam int AGE_W = $clog2(TIMEOUT + 1);

   logic [TAG_W-1:0]     tag_mem_q [DEPTH];
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        occ_q, occ_d, stale_q, stale_d;
   logic [AGE_W-1:0]     age_q, age_d;
   logic                 db_valid_q, db_valid_d;
   logic [KEY_SIZE-1:0]  db_key_q, db_key_d;
   logic [FLAG_SIZE-1:0] db_flag_q, db_flag_d;
   logic                 vd_valid_q, vd_valid_d;
   logic [TAG_W-1:0]     vd_tag_q, vd_tag_d;
   logic [FLAG_SIZE-1:0] vd_flag_q, vd_flag_d;
   logic                 vd_drop_q, vd_drop_d;
   logic                 vd_tmo_q, vd_tmo_d;
   logic                 err_q, err_d;

   logic [CW:0]          credit_used;
   logic                 pkt_ready, push, resp_pop, tmo_pop, pop, occ_nz, stale_nz;

   // Stale timed-out requests still hold DB slots, so they consume credits too.
   assign credit_used = {1'b0, occ_q} + {1'b0, stale_q};
   assign pkt_ready   = (!db_valid_q || bus.db_in_ready) && (credit_used < (CW+1)'(DEPTH));
   assign push        = bus.pkt_valid && pkt_ready;
   assign occ_nz      = (occ_q != '0);
   assign stale_nz    = (stale_q != '0);
   assign resp_pop    = bus.db_out_valid && !stale_nz && occ_nz;
   assign tmo_pop     = occ_nz && !bus.db_out_valid && (age_q == AGE_W'(TIMEOUT));
   assign pop         = resp_pop || tmo_pop;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      occ_d      = occ_q + CW'(push) - CW'(pop);
      stale_d    = stale_q;
      age_d      = age_q;
      db_valid_d = db_valid_q;
      db_key_d   = db_key_q;
      db_flag_d  = db_flag_q;
      vd_valid_d = pop;
      vd_tag_d   = vd_tag_q;
      vd_flag_d  = vd_flag_q;
      vd_drop_d  = vd_drop_q;
      vd_tmo_d   = vd_tmo_q;
      err_d      = err_q;

      if (!db_valid_q || bus.db_in_ready) begin
         db_valid_d = push;
         if (push) begin
            db_key_d  = {bus.pkt_src_ip, bus.pkt_dst_ip, bus.pkt_dst_port, 16'h0000};
            db_flag_d = bus.pkt_op;
         end
      end
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

      if (bus.db_out_valid && stale_nz) stale_d = stale_q - CW'(1);
      else if (tmo_pop)                 stale_d = stale_q + CW'(1);
      if (bus.db_out_valid && !stale_nz && !occ_nz) err_d = 1'b1;

      if (pop || !occ_nz)               age_d = '0;
      else if (age_q != AGE_W'(TIMEOUT)) age_d = age_q + AGE_W'(1);

      // Timeouts fail open: report status 0 and let the packet through.
      if (pop) begin
         vd_tag_d  = tag_mem_q[rd_ptr_q];
         vd_flag_d = resp_pop ? bus.db_out_flag : '0;
         vd_drop_d = resp_pop && (bus.db_out_flag == FLAG_SIZE'(2) || bus.db_out_flag == FLAG_SIZE'(3));
         vd_tmo_d  = tmo_pop;
      end
   end

   always_ff @(posedge clk) begin
      if (push) tag_mem_q[wr_ptr_q] <= bus.pkt_tag;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
         stale_q    <= '0;
         age_q      <= '0;
         db_valid_q <= 1'b0;
         db_key_q   <= '0;
         db_flag_q  <= '0;
         vd_valid_q <= 1'b0;
         vd_tag_q   <= '0;
         vd_flag_q  <= '0;
         vd_drop_q  <= 1'b0;
         vd_tmo_q   <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
         stale_q    <= stale_d;
         age_q      <= age_d;
         db_valid_q <= db_valid_d;
         db_key_q   <= db_key_d;
         db_flag_q  <= db_flag_d;
         vd_valid_q <= vd_valid_d;
         vd_tag_q   <= vd_tag_d;
         vd_flag_q  <= vd_flag_d;
         vd_drop_q  <= vd_drop_d;
         vd_tmo_q   <= vd_tmo_d;
         err_q      <= err_d;
      end
   end

   assign bus.pkt_ready   = pkt_ready;
   assign bus.db_in_valid = db_valid_q;
   assign bus.db_in_key   = db_key_q;
   assign bus.db_in_flag  = db_flag_q;
   assign bus.vd_valid    = vd_valid_q;
   assign bus.vd_tag      = vd_tag_q;
   assign bus.vd_flag     = vd_flag_q;
   assign bus.vd_drop     = vd_drop_q;
   assign bus.vd_timeout  = vd_tmo_q;
   assign err_unexp_o     = err_q;

`ifdef DB_CLIENT_STATS_EN
   logic [31:0] stat_req_q, stat_drop_q, stat_tmo_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         stat_req_q  <= '0;
         stat_drop_q <= '0;
         stat_tmo_q  <= '0;
      end else begin
         if (db_valid_q && bus.db_in_ready) stat_req_q  <= stat_req_q + 32'd1;
         if (vd_valid_q && vd_drop_q)       stat_drop_q <= stat_drop_q + 32'd1;
         if (vd_valid_q && vd_tmo_q)        stat_tmo_q  <= stat_tmo_q + 32'd1;
      end
   end

   assign stat_req_o  = stat_req_q;
   assign stat_drop_o = stat_drop_q;
   assign stat_tmo_o  = stat_tmo_q;
`else
   assign stat_req_o  = 32'd0;
   assign stat_drop_o = 32'd0;
   assign stat_tmo_o  = 32'd0;
`endif
endmodule

// File: tb/tb_db_client.sv
// tb/tb_db_client.sv - Directed bench for db_client with TIMEOUT=16, DEPTH=8.
module tb_db_client;
   logic        clk = 1'b0;
   logic        rst;
   logic        err_unexp;
   logic [31:0] stat_req, stat_drop, stat_tmo;
   int          n_tests = 0;
   int          n_fail  = 0;
   int          waited;
   logic [95:0] key_exp;

   always #5 clk = ~clk;

   db_client_if #(.KEY_SIZE(96), .FLAG_SIZE(4), .TAG_W(8)) bus ();

   db_client #(
      .KEY_SIZE(96), .FLAG_SIZE(4), .TAG_W(8), .DEPTH(8), .TIMEOUT(16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus.slave),
      .err_unexp_o (err_unexp),
      .stat_req_o  (stat_req),
      .stat_drop_o (stat_drop),
      .stat_tmo_o  (stat_tmo)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_pkt(input logic [31:0] s, input logic [31:0] d, input logic [15:0] p,
                            input logic [3:0] op, input logic [7:0] tag);
      bus.pkt_valid    = 1'b1;
      bus.pkt_src_ip   = s;
      bus.pkt_dst_ip   = d;
      bus.pkt_dst_port = p;
      bus.pkt_op       = op;
      bus.pkt_tag      = tag;
   endtask

   task automatic respond(input logic [3:0] flag);
      bus.db_out_valid = 1'b1;
      bus.db_out_flag  = flag;
      step();
      bus.db_out_valid = 1'b0;
   endtask

   initial begin
      rst              = 1'b0;
      bus.pkt_valid    = 1'b0;
      bus.pkt_src_ip   = '0;
      bus.pkt_dst_ip   = '0;
      bus.pkt_dst_port = '0;
      bus.pkt_op       = '0;
      bus.pkt_tag      = '0;
      bus.db_in_ready  = 1'b1;
      bus.db_out_valid = 1'b0;
      bus.db_out_flag  = '0;
      step();
      step();
      chk("rst_db_valid", 96'(bus.db_in_valid), 96'd0);
      chk("rst_vd_valid", 96'(bus.vd_valid), 96'd0);
      chk("rst_key", bus.db_in_key, 96'd0);
      chk("rst_vd_tag", 96'(bus.vd_tag), 96'd0);
      chk("rst_err", 96'(err_unexp), 96'd0);
      chk("rst_pkt_ready", 96'(bus.pkt_ready), 96'd1);
      rst = 1'b1;

      // Single lookup
      drive_pkt(32'h0A000001, 32'h0A000002, 16'h1234, 4'd1, 8'h05);
      step();
      bus.pkt_valid = 1'b0;
      chk("single_valid", 96'(bus.db_in_valid), 96'd1);
      chk("single_key", bus.db_in_key, 96'h0A0000010A00000212340000);
      chk("single_flag", 96'(bus.db_in_flag), 96'd1);
      step();
      chk("single_hs_done", 96'(bus.db_in_valid), 96'd0);
      respond(4'd3);
      chk("single_vd_valid", 96'(bus.vd_valid), 96'd1);
      chk("single_vd_tag", 96'(bus.vd_tag), 96'h05);
      chk("single_vd_flag", 96'(bus.vd_flag), 96'd3);
      chk("single_vd_drop", 96'(bus.vd_drop), 96'd1);
      chk("single_vd_tmo", 96'(bus.vd_timeout), 96'd0);
      step();
      chk("single_vd_pulse", 96'(bus.vd_valid), 96'd0);
      chk("single_vd_hold", 96'(bus.vd_tag), 96'h05);

      // Fill: eight outstanding, ninth refused
      for (int i = 0; i < 8; i++) begin
         drive_pkt(32'hC0A80000 + 32'(i), 32'h08080808, 16'd53, 4'd1, 8'(i));
         #1;
         chk("fill_ready", 96'(bus.pkt_ready), 96'd1);
         step();
      end
      drive_pkt(32'hC0A80008, 32'h08080808, 16'd53, 4'd1, 8'd8);
      #1;
      chk("fill_full", 96'(bus.pkt_ready), 96'd0);
      step();
      bus.pkt_valid = 1'b0;
      respond(4'd1);
      chk("fill_vd_valid", 96'(bus.vd_valid), 96'd1);
      chk("fill_vd_tag0", 96'(bus.vd_tag), 96'd0);
      chk("fill_vd_drop", 96'(bus.vd_drop), 96'd0);
      #1;
      chk("fill_ready_back", 96'(bus.pkt_ready), 96'd1);
      for (int i = 1; i < 8; i++) begin
         respond(4'd0);
         chk("drain_vd_tag", 96'(bus.vd_tag), 96'(i));
         chk("drain_vd_valid", 96'(bus.vd_valid), 96'd1);
      end
      step();

      // Timeout and late response
      drive_pkt(32'h01020304, 32'h05060708, 16'h0050, 4'd1, 8'h30);
      step();
      bus.pkt_valid = 1'b0;
      waited = 0;
      while (!bus.vd_valid && waited < 40) begin
         step();
         waited++;
      end
      chk("tmo_latency", 96'(waited), 96'd17);
      chk("tmo_vd_tag", 96'(bus.vd_tag), 96'h30);
      chk("tmo_vd_timeout", 96'(bus.vd_timeout), 96'd1);
      chk("tmo_vd_drop", 96'(bus.vd_drop), 96'd0);
      chk("tmo_vd_flag", 96'(bus.vd_flag), 96'd0);
      respond(4'd2);
      chk("late_discard", 96'(bus.vd_valid), 96'd0);
      chk("late_no_err", 96'(err_unexp), 96'd0);
      drive_pkt(32'h01020304, 32'h05060708, 16'h0051, 4'd1, 8'h31);
      step();
      bus.pkt_valid = 1'b0;
      step();
      respond(4'd2);
      chk("post_tmo_valid", 96'(bus.vd_valid), 96'd1);
      chk("post_tmo_tag", 96'(bus.vd_tag), 96'h31);
      chk("post_tmo_drop", 96'(bus.vd_drop), 96'd1);
      chk("post_tmo_tmo", 96'(bus.vd_timeout), 96'd0);

      // Response arriving exactly when age reaches TIMEOUT
      drive_pkt(32'hAABBCCDD, 32'h11223344, 16'h0101, 4'd1, 8'h40);
      step();
      bus.pkt_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         step();
         chk("edge_no_early_vd", 96'(bus.vd_valid), 96'd0);
      end
      respond(4'd2);
      chk("edge_vd_valid", 96'(bus.vd_valid), 96'd1);
      chk("edge_vd_tag", 96'(bus.vd_tag), 96'h40);
      chk("edge_vd_tmo", 96'(bus.vd_timeout), 96'd0);
      chk("edge_vd_drop", 96'(bus.vd_drop), 96'd1);
      drive_pkt(32'hAABBCCDD, 32'h11223344, 16'h0102, 4'd1, 8'h41);
      step();
      bus.pkt_valid = 1'b0;
      respond(4'd1);
      chk("edge_stale0_valid", 96'(bus.vd_valid), 96'd1);
      chk("edge_stale0_tag", 96'(bus.vd_tag), 96'h41);
      chk("edge_stale0_drop", 96'(bus.vd_drop), 96'd0);

      // Backpressure holds the request and pushes only once
      bus.db_in_ready = 1'b0;
      drive_pkt(32'h11111111, 32'h22222222, 16'h5555, 4'd2, 8'h20);
      step();
      key_exp = 96'h111111112222222255550000;
      drive_pkt(32'h33333333, 32'h44444444, 16'h6666, 4'd3, 8'h21);
      for (int i = 0; i < 5; i++) begin
         chk("bp_ready", 96'(bus.pkt_ready), 96'd0);
         step();
         chk("bp_valid", 96'(bus.db_in_valid), 96'd1);
         chk("bp_key", bus.db_in_key, key_exp);
         chk("bp_flag", 96'(bus.db_in_flag), 96'd2);
      end
      bus.pkt_valid   = 1'b0;
      bus.db_in_ready = 1'b1;
      step();
      chk("bp_released", 96'(bus.db_in_valid), 96'd0);
      respond(4'd4);
      chk("bp_vd_tag", 96'(bus.vd_tag), 96'h20);
      chk("bp_vd_drop", 96'(bus.vd_drop), 96'd0);

      // Unexpected response proves only one entry was pushed
      respond(4'd3);
      chk("unexp_no_vd", 96'(bus.vd_valid), 96'd0);
      chk("unexp_err", 96'(err_unexp), 96'd1);
      step();
      step();
      chk("unexp_sticky", 96'(err_unexp), 96'd1);
`ifdef DB_CLIENT_STATS_EN
      chk("stat_req", 96'(stat_req), 96'd14);
      chk("stat_drop", 96'(stat_drop), 96'd3);
      chk("stat_tmo", 96'(stat_tmo), 96'd1);
`else
      chk("stat_req_tied", 96'(stat_req), 96'd0);
      chk("stat_drop_tied", 96'(stat_drop), 96'd0);
      chk("stat_tmo_tied", 96'(stat_tmo), 96'd0);
`endif
      rst = 1'b0;
      step();
      chk("err_cleared", 96'(err_unexp), 96'd0);
      chk("stat_cleared", 96'(stat_req), 96'd0);
      rst = 1'b1;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/db_client.md
Name: db_client

Overview:
- Network-side requester for the key-value filter DB: the initiator that drives the DB's in_key/in_flag/in_valid interface and consumes its out_valid/out_flag responses.
- Takes parsed packet header fields from the packet parser, packs them into the 96-bit tuple key and issues the DB operation.
- Tracks outstanding requests in order and returns one pass/drop verdict per packet, tagged, to the forwarding path.
- Recovers from lost DB responses by timeout.

Parameters:
- KEY_SIZE, 96: tuple key width.
- FLAG_SIZE, 4: op/status flag width.
- TAG_W, 8: packet tag width.
- DEPTH, 8: max outstanding DB requests; power of 2, at least 2.
- TIMEOUT, 1023: cycles a head request may wait before it is abandoned; at least 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- pkt_valid  in  1  header request valid.
- pkt_ready  out  1  header request accepted when valid&ready.
- pkt_src_ip  in  32  source IP.
- pkt_dst_ip  in  32  destination IP.
- pkt_dst_port  in  16  destination UDP port.
- pkt_op  in  FLAG_SIZE  DB operation code.
- pkt_tag  in  TAG_W  packet tag, returned with the verdict.
- db_in_key  out  KEY_SIZE  key to DB.
- db_in_flag  out  FLAG_SIZE  op to DB.
- db_in_valid  out  1  request valid to DB.
- db_in_ready  in  1  DB accepts request.
- db_out_valid  in  1  DB response strobe; in order, one per accepted request.
- db_out_flag  in  FLAG_SIZE  DB response status.
- vd_valid  out  1  verdict strobe, one cycle.
- vd_tag  out  TAG_W  tag of the judged packet.
- vd_flag  out  FLAG_SIZE  returned status; 0 on timeout.
- vd_drop  out  1  1 = drop packet.
- vd_timeout  out  1  verdict produced by timeout.
- err_unexp  out  1  sticky: response received with nothing outstanding.
- stat_req  out  32  statistics: requests issued.
- stat_drop  out  32  statistics: drop verdicts.
- stat_tmo  out  32  statistics: timeout verdicts.

Interface decisions:
- One clock, clk.
- Reset rst is synchronous and active-low.

Behaviour:
- Reset (rst=0 sampled on a clk edge) clears everything:
  - outputs: db_in_valid, vd_valid, vd_drop, vd_timeout, err_unexp, all stat_* = 0; db_in_key, db_in_flag, vd_tag, vd_flag = 0.
  - internal: tag FIFO empty, stale=0, age=0.
  - Reset mid-operation discards all outstanding state; no verdicts are emitted for them.
- Key packing: db_in_key = {src_ip, dst_ip, dst_port, 16'h0000}, src_ip in the MSBs.
- Request path:
  - Single output register, valid/ready semantics: db_in_valid and its data hold until db_in_ready.
  - pkt_ready = (!db_in_valid | db_in_ready) & (occ + stale < DEPTH), where occ = FIFO count.
  - On accept, next cycle: db_in_valid=1, key and op registered; {tag} pushed into the FIFO in the same cycle.
  - A push and a pop in the same cycle are both honoured.
- Response path, with head = FIFO head:
  - db_out_valid & stale>0: response discarded, stale decrements, no verdict.
  - db_out_valid & stale=0 & occ>0: pop head; next cycle vd_valid=1, vd_tag=head tag, vd_flag=db_out_flag, vd_timeout=0.
    - vd_drop=1 iff db_out_flag is ARREST(2) or FILTERED(3); SUSPECTION(1), EXPIRED(4) and others pass.
  - db_out_valid & stale=0 & occ=0: ignored; err_unexp is set and held until reset.
- Timeout:
  - age counter (width clog2(TIMEOUT+1)) counts while occ>0 and no pop occurs.
  - age clears on any head pop or when the FIFO is empty.
  - When age==TIMEOUT and no db_out_valid that cycle: pop head, stale increments; next cycle vd_valid=1, vd_timeout=1, vd_flag=0, vd_drop=0 (fail open).
  - db_out_valid in the same cycle as age==TIMEOUT: the response wins and no timeout occurs.
- Credit invariant: occ + stale <= DEPTH always.
- Verdict latency: 1 cycle after db_out_valid or after the timeout pop.
- vd_* outputs are registered. vd_tag/vd_flag/vd_drop/vd_timeout hold their last value when vd_valid=0.

Optional Feature:
- Macro: DB_CLIENT_STATS_EN.
- Defined:
  - stat_req increments on each db_in_valid&db_in_ready handshake.
  - stat_drop increments on each vd_valid&vd_drop.
  - stat_tmo increments on each vd_valid&vd_timeout.
  - All wrap at 2^32 and reset to 0.
- Not defined: the stat_* ports are present but tied to 0, and no counter logic is built.

Test Plan:
- Single lookup: rst=0 for 2 cycles, then src=0x0A000001, dst=0x0A000002, port=0x1234, op=1, tag=0x05, db_in_ready=1.
  -> db_in_key=0x0A0000010A000002_1234_0000 one cycle later.
  -> DB returns flag=3 -> next cycle vd_valid=1, vd_tag=0x05, vd_flag=3, vd_drop=1.
- Fill: db_in_ready=1, 8 requests with tags 0..7, no responses.
  -> pkt_ready=0 on the 9th.
  -> one response flag=1 -> vd_tag=0, vd_drop=0, and pkt_ready returns to 1.
- Backpressure: db_in_ready=0 for 5 cycles with pkt_valid=1.
  -> db_in_valid stays 1, key stable, pkt_ready=0, exactly one FIFO push.
- Timeout with TIMEOUT=16: one request, no response for 16 cycles.
  -> vd_valid with vd_timeout=1, vd_drop=0.
  -> late response flag=2 is discarded (no vd_valid), stale returns to 0, next request is judged normally.
- Response on the exact timeout cycle: db_out_valid at age==TIMEOUT with flag=2 -> vd_timeout=0, vd_drop=1, stale stays 0.
- Unexpected response: db_out_valid with nothing outstanding -> err_unexp=1, no vd_valid, err_unexp cleared only by rst=0.
